// File: rtl/sram_bus_arbiter.sv
// Arbitrates the cartridge SRAM between the SNES read port and the AVR read/write port,
// sequencing the active-low strobes with programmable wait states and owning the AVR address counter.
module sram_bus_arbiter #(
    parameter int ADDR_W       = 21,
    parameter int DATA_W       = 8,
    parameter int RD_WAIT      = 2,
    parameter int WR_WAIT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              avr_clk,
    input  logic              avr_reset,
    input  logic              snes_mode,
    input  logic              snes_req,
    input  logic [ADDR_W-1:0] snes_addr,
    output logic [DATA_W-1:0] snes_rdata,
    output logic              snes_valid,
    input  logic              avr_req,
    input  logic              avr_wr,
    input  logic [DATA_W-1:0] avr_wdata,
    input  logic              avr_addr_load,
    input  logic [ADDR_W-1:0] avr_addr_in,
    output logic [ADDR_W-1:0] avr_addr,
    output logic [DATA_W-1:0] avr_rdata,
    output logic              avr_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_data_oe,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    // state   | meaning
    // IDLE    | strobes released, arbitrating every cycle
    // RD      | ce_n/oe_n low, wait down-counter running
    // WR      | ce_n/we_n low, data driven, wait down-counter running
    // RECOVER | strobes released, ack/valid pulse, write data held

    localparam int WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(WR_WAIT - 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RECOVER} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [SW-1:0]    starve_cnt;
    logic             own_snes;
    logic             own_wr;
    logic             snes_ok;
    logic             grant_snes;
    logic             grant_avr;
    logic             wait_done;

    // SNES is only held off at the starve limit while the AVR is actually waiting,
    // so a dropped avr_req can never lock the SNES out.
    always_comb begin
        snes_ok    = snes_mode & snes_req & ((starve_cnt != STARVE_MAX) | ~avr_req);
        grant_snes = (state == ST_IDLE) & snes_ok;
        grant_avr  = (state == ST_IDLE) & ~snes_ok & avr_req;
        wait_done  = (wait_cnt == '0);
    end

    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (grant_snes)     state_nxt = ST_RD;
                else if (grant_avr) state_nxt = avr_wr ? ST_WR : ST_RD;
            end
            ST_RD:      if (wait_done) state_nxt = ST_RECOVER;
            ST_WR:      if (wait_done) state_nxt = ST_RECOVER;
            ST_RECOVER: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_data_oe = 1'b0;
        snes_valid   = 1'b0;
        avr_ack      = 1'b0;
        busy         = (state != ST_IDLE);
        unique case (state)
            ST_RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            ST_WR: begin
                sram_ce_n    = 1'b0;
                sram_we_n    = 1'b0;
                sram_data_oe = 1'b1;
            end
            ST_RECOVER: begin
                sram_data_oe = own_wr;
                snes_valid   = own_snes;
                avr_ack      = ~own_snes;
            end
            default: ;
        endcase
    end

    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            own_snes   <= 1'b0;
            own_wr     <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            snes_rdata <= '0;
            avr_rdata  <= '0;
        end else begin
            if (grant_snes) begin
                own_snes  <= 1'b1;
                own_wr    <= 1'b0;
                sram_addr <= snes_addr;
                wait_cnt  <= RD_LOAD;
                if (avr_req) starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_avr) begin
                own_snes   <= 1'b0;
                own_wr     <= avr_wr;
                sram_addr  <= avr_addr;
                wait_cnt   <= avr_wr ? WR_LOAD : RD_LOAD;
                starve_cnt <= '0;
                if (avr_wr) sram_wdata <= avr_wdata;
            end else if ((state == ST_RD || state == ST_WR) && !wait_done) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == ST_RD && wait_done) begin
                if (own_snes) snes_rdata <= sram_rdata;
                else          avr_rdata  <= sram_rdata;
            end
        end
    end

    // The in-flight access already captured its address, so a load here never disturbs it.
    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset)                            avr_addr <= '0;
        else if (avr_addr_load)                   avr_addr <= avr_addr_in;
        else if (state == ST_RECOVER && !own_snes) avr_addr <= avr_addr + 1'b1;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: small SRAM model, expected-result queue popped on ack/valid.
module tb_sram_bus_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;

    logic              avr_clk;
    logic              avr_reset;
    logic              snes_mode;
    logic              snes_req;
    logic [ADDR_W-1:0] snes_addr;
    logic [DATA_W-1:0] snes_rdata;
    logic              snes_valid;
    logic              avr_req;
    logic              avr_wr;
    logic [DATA_W-1:0] avr_wdata;
    logic              avr_addr_load;
    logic [ADDR_W-1:0] avr_addr_in;
    logic [ADDR_W-1:0] avr_addr;
    logic [DATA_W-1:0] avr_rdata;
    logic              avr_ack;
    logic              busy;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_data_oe;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    sram_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(2), .WR_WAIT(2), .STARVE_LIMIT(4)
    ) dut (
        .avr_clk(avr_clk), .avr_reset(avr_reset), .snes_mode(snes_mode), .snes_req(snes_req),
        .snes_addr(snes_addr), .snes_rdata(snes_rdata), .snes_valid(snes_valid),
        .avr_req(avr_req), .avr_wr(avr_wr), .avr_wdata(avr_wdata),
        .avr_addr_load(avr_addr_load), .avr_addr_in(avr_addr_in), .avr_addr(avr_addr),
        .avr_rdata(avr_rdata), .avr_ack(avr_ack), .busy(busy), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    initial avr_clk = 1'b0;
    always #5 avr_clk = ~avr_clk;

    // SRAM model keyed by the low address byte; default contents are addr ^ 0x5A.
    logic [7:0] mem [0:255];
    assign sram_rdata = mem[sram_addr[7:0]];
    always @(posedge avr_clk)
        if (!avr_reset && !sram_ce_n && !sram_we_n && sram_data_oe)
            mem[sram_addr[7:0]] <= sram_wdata;

    typedef struct {
        bit         is_snes;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic avr_access(input bit wr, input logic [7:0] wd, input logic [20:0] addr,
                              input logic [7:0] rd_exp, input logic [20:0] next_addr);
        int   lat;
        int   we_cnt;
        int   oe_cnt;
        bit   got;
        exp_t e;
        lat = 0; we_cnt = 0; oe_cnt = 0; got = 0;
        @(negedge avr_clk);
        avr_addr_load = 1'b1;
        avr_addr_in   = addr;
        @(negedge avr_clk);
        avr_addr_load = 1'b0;
        sb.push_back('{1'b0, rd_exp});
        avr_wr    = wr;
        avr_wdata = wd;
        avr_req   = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge avr_clk);
            if (busy) lat++;
            if (!sram_we_n) begin
                we_cnt++;
                check("wr_addr", sram_addr, addr);
                check("wr_data_oe", sram_data_oe, 1'b1);
                check("wr_data", sram_wdata, wd);
            end
            if (!sram_oe_n) begin
                oe_cnt++;
                check("rd_addr", sram_addr, addr);
            end
            if (avr_ack) begin
                got = 1'b1;
                check("recover_data_oe", sram_data_oe, wr);
                check("recover_ce_n", sram_ce_n, 1'b1);
            end
        end
        avr_req = 1'b0;
        check("avr_ack_seen", got, 1'b1);
        e = sb.pop_front();
        if (!wr) check("avr_rdata", avr_rdata, e.data);
        check("avr_latency", lat, 3);
        check("we_cycles", we_cnt, wr ? 2 : 0);
        check("oe_cycles", oe_cnt, wr ? 0 : 2);
        @(negedge avr_clk);
        check("avr_addr_next", avr_addr, next_addr);
        check("idle_after", busy, 1'b0);
    endtask

    initial begin
        exp_t e;
        int   n_valid;
        int   n_busy;
        bit   got;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'hFF] = 8'hAA;
        avr_reset = 1'b1;
        snes_mode = 1'b0; snes_req = 1'b0; snes_addr = '0;
        avr_req = 1'b0; avr_wr = 1'b0; avr_wdata = '0;
        avr_addr_load = 1'b0; avr_addr_in = '0;

        repeat (2) @(negedge avr_clk);
        check("rst_ce_n", sram_ce_n, 1'b1);
        check("rst_oe_n", sram_oe_n, 1'b1);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_data_oe", sram_data_oe, 1'b0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_snes_rdata", snes_rdata, 0);
        check("rst_avr_rdata", avr_rdata, 0);
        check("rst_valid_ack", {snes_valid, avr_ack}, 0);
        avr_reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge avr_clk);
            check("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
            check("idle_busy", busy, 1'b0);
            check("idle_avr_addr", avr_addr, 0);
        end

        avr_access(1'b1, 8'hEE, 21'h004CCF, 8'h00, 21'h004CD0);
        avr_access(1'b0, 8'h00, 21'h1FFFFF, 8'hAA, 21'h000000);
        avr_access(1'b0, 8'h00, 21'h004CCF, 8'hEE, 21'h004CD0);

        // Both requesters held: four SNES grants, a forced AVR grant, then SNES again.
        for (int i = 0; i < 4; i++) sb.push_back('{1'b1, 8'h23 ^ 8'h5A});
        sb.push_back('{1'b0, 8'hD0 ^ 8'h5A});
        sb.push_back('{1'b1, 8'h23 ^ 8'h5A});
        snes_addr = 21'h000123;
        snes_mode = 1'b1;
        avr_wr    = 1'b0;
        snes_req  = 1'b1;
        avr_req   = 1'b1;
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            @(negedge avr_clk);
            if (snes_valid || avr_ack) begin
                e = sb.pop_front();
                check("grant_order", snes_valid, e.is_snes);
                check("single_pulse", snes_valid & avr_ack, 1'b0);
                check("starve_rdata", e.is_snes ? snes_rdata : avr_rdata, e.data);
                if (sb.size() == 0) begin
                    snes_req = 1'b0;
                    avr_req  = 1'b0;
                end
            end
        end
        check("starve_remaining", sb.size(), 0);
        @(negedge avr_clk);
        check("starve_avr_addr", avr_addr, 21'h004CD1);

        snes_mode = 1'b0;
        snes_addr = 21'h123456;
        snes_req  = 1'b1;
        n_valid = 0; n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge avr_clk);
            if (snes_valid) n_valid++;
            if (busy) n_busy++;
        end
        snes_req = 1'b0;
        check("mode0_valid", n_valid, 0);
        check("mode0_busy", n_busy, 0);

        // snes_mode drops while an SNES read is in flight; the read still completes.
        snes_addr = 21'h000045;
        snes_mode = 1'b1;
        snes_req  = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge avr_clk);
            got = busy;
        end
        snes_mode = 1'b0;
        snes_req  = 1'b0;
        check("mode_drop_grant", got, 1'b1);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge avr_clk);
            got = snes_valid;
        end
        check("mode_drop_valid", got, 1'b1);
        check("mode_drop_rdata", snes_rdata, 8'h45 ^ 8'h5A);

        // Reset asserted mid-write, away from any clock edge.
        @(negedge avr_clk);
        avr_addr_load = 1'b1;
        avr_addr_in   = 21'h000010;
        @(negedge avr_clk);
        avr_addr_load = 1'b0;
        avr_wr    = 1'b1;
        avr_wdata = 8'h33;
        avr_req   = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge avr_clk);
            got = !sram_we_n;
        end
        check("mid_wr_reached", got, 1'b1);
        #2 avr_reset = 1'b1;
        #1;
        check("async_we_n", sram_we_n, 1'b1);
        check("async_ce_n", sram_ce_n, 1'b1);
        check("async_data_oe", sram_data_oe, 1'b0);
        check("async_busy", busy, 1'b0);
        avr_req = 1'b0;
        repeat (2) @(negedge avr_clk);
        avr_reset = 1'b0;
        n_valid = 0; n_busy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge avr_clk);
            if (avr_ack) n_valid++;
            if (busy) n_busy++;
        end
        check("post_rst_ack", n_valid, 0);
        check("post_rst_busy", n_busy, 0);
        check("post_rst_avr_addr", avr_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
